// File: rtl/seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// seq_pattern_detector
//   Serial pattern detector. It shifts in one bit on every cycle where
//   din_valid is high and compares the newest LEN bits with PATTERN.
//   On a hit it drives a registered one-cycle match pulse and advances a
//   saturating hit counter. cnt_sat is a sticky flag that is set when the
//   counter reaches all-ones.
//
//   Build option: SEQ_DET_OVERLAP_EN
//     defined   - overlapping detection. History is kept after a hit.
//     undefined - non-overlapping detection. A hit clears the history and
//                 the fill level, and the FSM returns to FILL.
// ---------------------------------------------------------------------------
module seq_pattern_detector #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             count_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_sat,
  output logic             armed
);

  localparam int             FW      = $clog2(LEN + 1);
  localparam logic [FW-1:0]  LEN_C   = FW'(LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [LEN-1:0]   hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [LEN-1:0]   hist_shift_s;
  logic [FW-1:0]    fill_inc_s;
  logic             full_s;
  logic             hit_s;

  // Next history, fill and state. din is only looked at on an accepting edge.
  always_comb begin
    hist_d       = hist_q;
    fill_d       = fill_q;
    state_d      = state_q;
    hist_shift_s = hist_q;
    fill_inc_s   = fill_q;
    full_s       = 1'b0;
    hit_s        = 1'b0;
    if (din_valid) begin
      hist_shift_s = {hist_q[LEN-2:0], din};
      fill_inc_s   = (fill_q == LEN_C) ? LEN_C : (fill_q + FW'(1));
      full_s       = (fill_inc_s == LEN_C);
      // A hit is possible once armed, or on the edge that completes the fill.
      hit_s        = ((state_q == ST_ARMED) || full_s) && (hist_shift_s == PATTERN);

      case (state_q)
        ST_FILL:  state_d = full_s ? ST_ARMED : ST_FILL;
        ST_ARMED: state_d = ST_ARMED;
        default:  state_d = ST_FILL;
      endcase

`ifdef SEQ_DET_OVERLAP_EN
      hist_d = hist_shift_s;
      fill_d = fill_inc_s;
`else
      // Non-overlapping: a hit consumes the whole window.
      if (hit_s) begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = ST_FILL;
      end else begin
        hist_d = hist_shift_s;
        fill_d = fill_inc_s;
      end
`endif
    end else begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      state_d = state_q;
    end
  end

  // Next match pulse, saturating counter and sticky saturation flag.
  // count_clr beats a simultaneous hit, but the pulse is still emitted.
  always_comb begin
    match_d = hit_s;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (count_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (hit_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
      sat_d = sat_q | ((cnt_q + CNT_W'(1)) == CNT_MAX);
    end else begin
      cnt_d = cnt_q;
      sat_d = sat_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign cnt_sat     = sat_q;
  assign armed       = (state_q == ST_ARMED);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_detector
//   Directed scenarios followed by randomized stimulus. The reference model
//   stores the accepted bits in a queue, limited to the last LEN bits. It
//   uses an integer hit counter. The DUT is built with CNT_W=2 so that
//   saturation is reached quickly.
// ---------------------------------------------------------------------------
module tb_seq_pattern_detector;

  localparam int          LEN     = 4;
  localparam logic [3:0]  PATTERN = 4'b1011;
  localparam int          CNT_W   = 2;
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             din_valid;
  logic             din;
  logic             count_clr;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             cnt_sat;
  logic             armed;

  int n_checks;
  int n_errors;

  // Reference model state
  bit m_bits[$];
  int m_count;
  bit m_sat;
  bit m_match;

  seq_pattern_detector #(
    .LEN     (LEN),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din_valid   (din_valid),
    .din         (din),
    .count_clr   (count_clr),
    .match       (match),
    .match_count (match_count),
    .cnt_sat     (cnt_sat),
    .armed       (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge in the reference model, using the spec rules directly.
  task automatic model_edge(input bit r, input bit v, input bit d, input bit c);
    int  val;
    bit  hit;
    if (r) begin
      m_bits.delete();
      m_count = 0;
      m_sat   = 1'b0;
      m_match = 1'b0;
    end else begin
      hit = 1'b0;
      if (v) begin
        m_bits.push_back(d);
        if (m_bits.size() > LEN) void'(m_bits.pop_front());
        if (m_bits.size() == LEN) begin
          val = 0;
          foreach (m_bits[i]) val = (val << 1) | int'(m_bits[i]);
          hit = (val == int'(PATTERN));
        end
`ifndef SEQ_DET_OVERLAP_EN
        if (hit) m_bits.delete();
`endif
      end
      if (c) begin
        m_count = 0;
        m_sat   = 1'b0;
      end else if (hit) begin
        if (m_count < CMAX) m_count++;
        if (m_count == CMAX) m_sat = 1'b1;
      end
      m_match = hit;
    end
  endtask

  // Drive one cycle, advance the model, and compare all outputs after the edge.
  task automatic step(input bit r, input bit v, input bit d, input bit c);
    reset     = r;
    din_valid = v;
    din       = v ? d : 1'bx;
    count_clr = c;
    @(posedge clk);
    model_edge(r, v, d, c);
    #1;
    check_eq("match", {31'd0, match}, {31'd0, m_match});
    check_eq("match_count", {{(32-CNT_W){1'b0}}, match_count}, m_count);
    check_eq("cnt_sat", {31'd0, cnt_sat}, {31'd0, m_sat});
    check_eq("armed", {31'd0, armed}, (m_bits.size() == LEN) ? 32'd1 : 32'd0);
  endtask

  task automatic send_bits(input logic [3:0] b, input int gap);
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 1'b1, b[i], 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bit r, v, d, c;
    n_checks  = 0;
    n_errors  = 0;
    m_count   = 0;
    m_sat     = 1'b0;
    m_match   = 1'b0;
    reset     = 1'b1;
    din_valid = 1'b0;
    din       = 1'b0;
    count_clr = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rst_count", {{(32-CNT_W){1'b0}}, match_count}, 32'd0);
    check_eq("rst_armed", {31'd0, armed}, 32'd0);

    // 1. Basic hit
    send_bits(4'b1011, 0);
    check_eq("t1_match", {31'd0, match}, 32'd1);
    check_eq("t1_count", {{(32-CNT_W){1'b0}}, match_count}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t1_pulse_end", {31'd0, match}, 32'd0);

    // 2. Overlap: 1,0,1,1,0,1,1
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(4'b1011, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
`ifdef SEQ_DET_OVERLAP_EN
    check_eq("t2_count", {{(32-CNT_W){1'b0}}, match_count}, 32'd2);
`else
    check_eq("t2_count", {{(32-CNT_W){1'b0}}, match_count}, 32'd1);
`endif

    // 3. Valid gaps of 3 cycles between bits
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(4'b1011, 3);
    check_eq("t3_count", {{(32-CNT_W){1'b0}}, match_count}, 32'd1);

    // 4. Saturation with a 2-bit counter, then clear
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int h = 0; h < 5; h++) send_bits(4'b1011, 0);
    check_eq("t4_count", {{(32-CNT_W){1'b0}}, match_count}, 32'd3);
    check_eq("t4_sat", {31'd0, cnt_sat}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t4_clr_count", {{(32-CNT_W){1'b0}}, match_count}, 32'd0);
    check_eq("t4_clr_sat", {31'd0, cnt_sat}, 32'd0);

    // 5. Reset mid-pattern, then 1,0,1,1 must be needed again from scratch
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("t5_armed", {31'd0, armed}, 32'd0);
    check_eq("t5_count", {{(32-CNT_W){1'b0}}, match_count}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    // 6. Clear on the same edge as a hit
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("t6_match", {31'd0, match}, 32'd1);
    check_eq("t6_count", {{(32-CNT_W){1'b0}}, match_count}, 32'd0);
    check_eq("t6_sat", {31'd0, cnt_sat}, 32'd0);

    // Randomized stimulus
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 7);
      d = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 59) == 0);
      step(r, v, d, c);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
